accum_alu: RTL

Parametrised, handshaked accumulator ALU. It is the next-generation replacement for the 8-bit single-cycle ALU.
- Accepts one operation per valid/ready handshake and writes the result into an internal DATALEN-bit accumulator.
- Reports a 2-bit error code per operation.
- Adds barrel-free iterative multi-bit shifts and a shift-add multiply, with a small FSM.
- Sits between the command/test sequencer and the result display/string-decode logic.

---
 rtl/accum_alu_if.sv | 26 ++
 rtl/accum_alu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/accum_alu_if.sv
// Operation request / result bundle for accum_alu.
// The sequencer uses the master side; the ALU uses the slave side.
interface accum_alu_if #(
  parameter int DATALEN  = 8,
  parameter int MODELEN  = 4,
  parameter int ERRORLEN = 2
);
  logic [DATALEN-1:0]  in_a;
  logic [DATALEN-1:0]  in_b;
  logic [MODELEN-1:0]  mode;
  logic                op_valid;
  logic                op_ready;
  logic [DATALEN-1:0]  out;
  logic [ERRORLEN-1:0] error;
  logic                done;

  modport master (
    output in_a, in_b, mode, op_valid,
    input  op_ready, out, error, done
  );

  modport slave (
    input  in_a, in_b, mode, op_valid,
    output op_ready, out, error, done
  );
endinterface

// File: rtl/accum_alu.sv
// Handshaked accumulator ALU: logic/arith ops finish at the accept edge, shifts take min(in_b,DATALEN) cycles, multiply DATALEN.
// op_ready is low while a shift or multiply iterates; clear drops any in-flight op and refuses that cycle's request.
module accum_alu #(
  parameter int DATALEN  = 8,
  parameter int MODELEN  = 4,
  parameter int ERRORLEN = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  accum_alu_if.slave   bus
);
  localparam int CW = $clog2(DATALEN + 1);

  localparam logic [MODELEN-1:0] OP_NOP = MODELEN'(0);
  localparam logic [MODELEN-1:0] OP_NOT = MODELEN'(1);
  localparam logic [MODELEN-1:0] OP_SHL = MODELEN'(2);
  localparam logic [MODELEN-1:0] OP_SHR = MODELEN'(3);
  localparam logic [MODELEN-1:0] OP_LD  = MODELEN'(4);
  localparam logic [MODELEN-1:0] OP_AND = MODELEN'(5);
  localparam logic [MODELEN-1:0] OP_OR  = MODELEN'(6);
  localparam logic [MODELEN-1:0] OP_XOR = MODELEN'(7);
  localparam logic [MODELEN-1:0] OP_ADD = MODELEN'(8);
  localparam logic [MODELEN-1:0] OP_SUB = MODELEN'(9);
  localparam logic [MODELEN-1:0] OP_MUL = MODELEN'(10);

  localparam logic [ERRORLEN-1:0] E_OK  = ERRORLEN'(0);
  localparam logic [ERRORLEN-1:0] E_OVF = ERRORLEN'(1);
  localparam logic [ERRORLEN-1:0] E_UNF = ERRORLEN'(2);
  localparam logic [ERRORLEN-1:0] E_ILL = ERRORLEN'(3);

  localparam logic [DATALEN-1:0] DLEN_V = DATALEN'(DATALEN);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t                state;
  logic [DATALEN-1:0]    acc;
  logic [ERRORLEN-1:0]   err;
  logic                  done_r;
  logic [DATALEN-1:0]    work;
  logic [DATALEN-1:0]    mplier;
  logic [2*DATALEN-1:0]  mcand;
  logic [2*DATALEN-1:0]  prod;
  logic [CW-1:0]         cnt;
  logic                  sticky;
  logic                  shl;

  logic                  accept;
  logic [DATALEN:0]      sum;
  logic [DATALEN:0]      diff;
  logic [DATALEN-1:0]    sc_acc;
  logic [ERRORLEN-1:0]   sc_err;
  logic                  go_shift;
  logic                  go_mul;
  logic [CW-1:0]         sh_cnt;
  logic                  sh_out;
  logic                  sticky_n;
  logic [DATALEN-1:0]    sh_next;
  logic [2*DATALEN-1:0]  prod_n;

  assign bus.op_ready = (state == IDLE);
  assign bus.out      = acc;
  assign bus.error    = err;
  assign bus.done     = done_r;

  assign accept = bus.op_valid && (state == IDLE) && !clear;

  always_comb begin
    sum      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    diff     = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    sc_acc   = acc;
    sc_err   = E_OK;
    go_shift = 1'b0;
    go_mul   = 1'b0;
    case (bus.mode)
      OP_NOP: sc_acc = acc;
      OP_NOT: sc_acc = ~bus.in_a;
      OP_SHL, OP_SHR: go_shift = (bus.in_b != '0);
      OP_LD:  sc_acc = bus.in_a;
      OP_AND: sc_acc = bus.in_a & bus.in_b;
      OP_OR:  sc_acc = bus.in_a | bus.in_b;
      OP_XOR: sc_acc = bus.in_a ^ bus.in_b;
      OP_ADD: begin
        sc_acc = sum[DATALEN-1:0];
        sc_err = sum[DATALEN] ? E_OVF : E_OK;
      end
      OP_SUB: begin
        sc_acc = diff[DATALEN-1:0];
        sc_err = diff[DATALEN] ? E_UNF : E_OK;
      end
      OP_MUL: go_mul = 1'b1;
      default: sc_err = E_ILL;
    endcase

    // Shifting past the word width can only ever yield zero, so cap the count.
    sh_cnt   = (bus.in_b >= DLEN_V) ? CW'(DATALEN) : CW'(bus.in_b);
    sh_out   = shl ? work[DATALEN-1] : work[0];
    sh_next  = shl ? (work << 1) : (work >> 1);
    sticky_n = sticky | sh_out;
    prod_n   = mplier[0] ? (prod + mcand) : prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      err    <= E_OK;
      done_r <= 1'b0;
      work   <= '0;
      mplier <= '0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      shl    <= 1'b0;
    end else if (clear) begin
      state  <= IDLE;
      acc    <= '0;
      err    <= E_OK;
      done_r <= 1'b0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_shift) begin
              work   <= acc;
              cnt    <= sh_cnt;
              sticky <= 1'b0;
              shl    <= (bus.mode == OP_SHL);
              state  <= SHIFT;
            end else if (go_mul) begin
              prod   <= '0;
              mcand  <= {{DATALEN{1'b0}}, bus.in_a};
              mplier <= bus.in_b;
              cnt    <= CW'(DATALEN);
              state  <= MUL;
            end else begin
              acc    <= sc_acc;
              err    <= sc_err;
              done_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work   <= sh_next;
          sticky <= sticky_n;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            acc    <= sh_next;
            err    <= sticky_n ? (shl ? E_OVF : E_UNF) : E_OK;
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        MUL: begin
          prod   <= prod_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            acc    <= prod_n[DATALEN-1:0];
            err    <= (prod_n[2*DATALEN-1:DATALEN] != '0) ? E_OVF : E_OK;
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
